// File: rtl/fixed_float_pkg.sv
// Shared types and constants for the fixed-point to IEEE-754 converter.
package fixed_float_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ABS   = 3'd1,
    ST_LOD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_ROUND = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  localparam int FIX_W_DEFAULT = 32;

  function automatic int calc_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic int calc_sw(input int w);
    return $clog2(w);
  endfunction

  localparam int SW = calc_sw(FIX_W_DEFAULT);

endpackage

// File: rtl/fixed_to_float_rne_lod.sv
// Combinational leading-one detector: position of the most significant set bit.
module leading_one_detector
  import fixed_float_pkg::*;
#(
  parameter int FIX_W = 32,
  parameter int PW    = calc_sw(FIX_W)
) (
  input  logic [FIX_W-1:0] i_d_in,
  output logic             o_zero,
  output logic [PW-1:0]    o_pos
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    o_zero = ~|i_d_in;
    o_pos  = '0;
    for (int i = 0; i < FIX_W; i++) begin
      if (i_d_in[i]) o_pos = PW'(i);
    end
  end

endmodule

// File: rtl/fixed_to_float_rne.sv
// Multi-cycle fixed-point to IEEE-754 converter, round-to-nearest-even, flush-to-zero.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module fixed_to_float_rne
  import fixed_float_pkg::*;
#(
  parameter int FIX_W  = 32,
  parameter int FRAC_W = 26,
  parameter int EW     = 8,
  parameter int MW     = 23,
  parameter bit SIGNED = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [FIX_W-1:0]    FIXED,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [EW+MW:0]      FLOATOUT,
  output logic                INEXACT,
  output logic                BUSY
);

  localparam int PW   = calc_sw(FIX_W);
  localparam int BIAS = calc_bias(EW);
  localparam int XW   = EW + 2;
  // Width of the below-leading-one field, padded so G and at least one S bit exist.
  localparam int NF   = (FIX_W - 1 > MW + 2) ? FIX_W - 1 : MW + 2;

  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EW) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  state_t r_state;
  state_t w_next;

  logic [FIX_W-1:0] r_fixed;
  logic             r_sign;
  logic [FIX_W-1:0] r_mag;
  logic             r_zero;
  logic [PW-1:0]    r_pos;
  logic [FIX_W-2:0] r_norm;
  logic [EW+MW:0]   r_float;
  logic             r_inexact;

  logic             w_lod_zero;
  logic [PW-1:0]    w_lod_pos;
  logic [PW-1:0]    w_shamt;
  logic [NF-1:0]    w_ext;
  logic [MW-1:0]    w_keep;
  logic             w_g;
  logic             w_s;
  logic             w_up;
  logic [MW:0]      w_sum;
  logic             w_carry;
  logic signed [XW-1:0] w_exp;
  logic [EW+MW:0]   w_float;
  logic             w_inexact;

  leading_one_detector #(.FIX_W(FIX_W), .PW(PW)) u_lod (
    .i_d_in (r_mag),
    .o_zero (w_lod_zero),
    .o_pos  (w_lod_pos)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (IN_VALID) w_next = ST_ABS;
      ST_ABS:   w_next = ST_LOD;
      ST_LOD:   w_next = ST_NORM;
      ST_NORM:  w_next = ST_ROUND;
      ST_ROUND: w_next = ST_HOLD;
      ST_HOLD:  if (OUT_READY) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    BUSY      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        IN_READY = 1'b1;
        BUSY     = 1'b0;
      end
      ST_HOLD: OUT_VALID = 1'b1;
      default: ;
    endcase
  end

  assign FLOATOUT = r_float;
  assign INEXACT  = r_inexact;

  // The leading one is implicit after normalisation, so only the bits below it are kept.
  assign w_shamt = PW'(FIX_W - 1) - r_pos;
  assign w_ext   = NF'(r_norm) << (NF - (FIX_W - 1));
  assign w_keep  = w_ext[NF-1 -: MW];
  assign w_g     = w_ext[NF-MW-1];
  assign w_s     = |w_ext[NF-MW-2:0];
  assign w_up    = w_g & (w_s | w_keep[0]);
  assign w_sum   = {1'b0, w_keep} + (MW+1)'(w_up);
  assign w_carry = w_sum[MW];
  assign w_exp   = $signed(XW'(r_pos)) + $signed(XW'(BIAS - FRAC_W)) + $signed(XW'(w_carry));

  always_comb begin
    w_float   = {r_sign, w_exp[EW-1:0], w_sum[MW-1:0]};
    w_inexact = w_g | w_s;
    if (r_zero) begin
      w_float   = '0;
      w_inexact = 1'b0;
    end else if (w_exp >= EXP_MAX) begin
      w_float   = {r_sign, {EW{1'b1}}, {MW{1'b0}}};
      w_inexact = 1'b1;
    end else if (w_exp <= EXP_ZERO) begin
      w_float   = {r_sign, {(EW+MW){1'b0}}};
      w_inexact = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_fixed   <= '0;
      r_sign    <= 1'b0;
      r_mag     <= '0;
      r_zero    <= 1'b0;
      r_pos     <= '0;
      r_norm    <= '0;
      r_float   <= '0;
      r_inexact <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (IN_VALID) begin
            r_fixed <= FIXED;
            r_sign  <= SIGNED & FIXED[FIX_W-1];
          end
        end
        // Most-negative input negates to itself, which reads correctly as unsigned.
        ST_ABS:   r_mag  <= r_sign ? FIX_W'(-r_fixed) : r_fixed;
        ST_LOD: begin
          r_zero <= w_lod_zero;
          r_pos  <= w_lod_pos;
        end
        ST_NORM:  r_norm <= (FIX_W-1)'(r_mag << w_shamt);
        ST_ROUND: begin
          r_float   <= w_float;
          r_inexact <= w_inexact;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_float_rne.sv
// Bench for fixed_to_float_rne: directed corner cases, backpressure, mid-conversion reset, random.
module tb_fixed_to_float_rne;

  localparam int FIX_W  = 32;
  localparam int FRAC_W = 26;
  localparam int EW     = 8;
  localparam int MW     = 23;
  localparam int BIAS   = 127;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] FIXED = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] FLOATOUT;
  logic        INEXACT;
  logic        BUSY;

  logic [32:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int n_chk = 0;

  always #5 CLK = ~CLK;

  fixed_to_float_rne #(
    .FIX_W(FIX_W), .FRAC_W(FRAC_W), .EW(EW), .MW(MW), .SIGNED(1'b1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .FIXED     (FIXED),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .FLOATOUT  (FLOATOUT),
    .INEXACT   (INEXACT),
    .BUSY      (BUSY)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Reference: exact integer rounding of |x| to MW+1 significant bits, ties to even.
  function automatic logic [32:0] ref_model(input logic [31:0] v);
    longint x, m, q, rem, half;
    int p, e, sh;
    logic s, inx, up;
    logic [31:0] f;
    x = longint'($signed(v));
    s = (x < 0);
    m = s ? -x : x;
    if (m == 0) return 33'd0;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    inx = 1'b0;
    if (p > MW) begin
      sh   = p - MW;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      inx  = (rem != 0);
      up   = (rem > half) || ((rem == half) && q[0]);
      if (up) q = q + 1;
      if (q == (longint'(1) << (MW + 1))) begin
        q = q >> 1;
        p = p + 1;
      end
    end else begin
      q = m << (MW - p);
    end
    e = p - FRAC_W + BIAS;
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    if (e <= 0)   return {1'b1, s, 31'd0};
    f = {s, e[7:0], q[22:0]};
    return {inx, f};
  endfunction

  function automatic logic [31:0] gen_operand();
    logic [31:0] v, mask;
    logic [31:0] corners [8];
    int p, sh;
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                32'h80000000, 32'h80000001, 32'h00FFFFFF, 32'h01000000};
    case ($urandom_range(0, 5))
      0: v = $urandom();
      1: v = $urandom() >> $urandom_range(0, 31);
      2: v = -($urandom() >> $urandom_range(8, 31));
      3: begin
        p    = $urandom_range(25, 30);
        sh   = p - MW;
        mask = (32'd1 << (sh - 1)) - 1;
        v    = (((32'd1 << p) | ($urandom() & ((32'd1 << p) - 1))) & ~mask) & ~(32'd1 << (sh - 1));
        v    = v | (32'd1 << (sh - 1));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      4: v = corners[$urandom_range(0, 7)];
      default: begin
        v = (32'd1 << $urandom_range(1, 31)) - 1;
        if ($urandom_range(0, 1) == 1) v = -v;
      end
    endcase
    return v;
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!IN_READY && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (!IN_READY) begin
      n_err++;
      $display("FAIL in_ready_timeout: got IN_READY=0, want 1 within 50 cycles");
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] v, input logic [32:0] e);
    wait_ready();
    IN_VALID = 1'b1;
    FIXED    = v;
    exp_q.push_back(e);
    n_vec++;
    @(negedge CLK);
    IN_VALID = 1'b0;
    FIXED    = $urandom();
  endtask

  initial begin
    logic [32:0] e;
    forever begin
      @(negedge CLK);
      #1;
      if (RST && OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result: got %h, want no result", {INEXACT, FLOATOUT});
        end else begin
          e = exp_q.pop_front();
          check("result", {31'b0, INEXACT, FLOATOUT}, {31'b0, e});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] dir_v [9];
    logic [32:0] dir_e [9];
    logic [31:0] v;
    int t;
    dir_v = '{32'h04000000, 32'hFC000000, 32'h00000000, 32'h04000004, 32'h0400000C,
              32'h7FFFFFFF, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
    dir_e = '{{1'b0, 32'h3F800000}, {1'b0, 32'hBF800000}, {1'b0, 32'h00000000},
              {1'b1, 32'h3F800000}, {1'b1, 32'h3F800002}, {1'b1, 32'h42000000},
              {1'b0, 32'hC2000000}, {1'b0, 32'h32800000}, {1'b0, 32'hB2800000}};

    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_floatout", FLOATOUT, 0);
    check("rst_inexact", INEXACT, 0);
    check("rst_busy", BUSY, 0);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_in_ready", IN_READY, 1);

    OUT_READY = 1'b1;
    send(32'h04000000, {1'b0, 32'h3F800000});
    check("accept_busy", BUSY, 1);
    check("accept_in_ready", IN_READY, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      check("latency_out_valid", OUT_VALID, (i == 4));
    end
    @(negedge CLK);
    check("reidle_in_ready", IN_READY, 1);

    for (int i = 0; i < 9; i++) begin
      send(dir_v[i], dir_e[i]);
      wait_ready();
    end

    OUT_READY = 1'b0;
    send(32'h7FFFFFFF, {1'b1, 32'h42000000});
    t = 0;
    while (!OUT_VALID && t < 20) begin
      @(negedge CLK);
      t++;
    end
    check("hold_reached", OUT_VALID, 1);
    repeat (10) begin
      IN_VALID = 1'($urandom_range(0, 1));
      FIXED    = $urandom();
      @(negedge CLK);
      check("hold_out_valid", OUT_VALID, 1);
      check("hold_floatout", FLOATOUT, 32'h42000000);
      check("hold_inexact", INEXACT, 1);
      check("hold_in_ready", IN_READY, 0);
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    wait_ready();
    repeat (2) @(negedge CLK);
    check("pulse_not_queued", BUSY, 0);

    IN_VALID = 1'b1;
    FIXED    = 32'h12345678;
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("abort_out_valid", OUT_VALID, 0);
    check("abort_floatout", FLOATOUT, 0);
    check("abort_inexact", INEXACT, 0);
    check("abort_busy", BUSY, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    send(32'h04000000, {1'b0, 32'h3F800000});
    wait_ready();

    for (int i = 0; i < 300; i++) begin
      v = gen_operand();
      OUT_READY = ($urandom_range(0, 3) != 0);
      send(v, ref_model(v));
      if (!OUT_READY) begin
        repeat ($urandom_range(4, 9)) @(negedge CLK);
        OUT_READY = 1'b1;
      end
      wait_ready();
    end

    repeat (3) @(negedge CLK);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
